// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditional add into the upper half, then shift right by one.
module mult_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-2:0] lo_upper,
    input  logic [WIDTH-1:0] mcand,
    input  logic             bit_in,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;

    // Carry-out of the add re-enters at the MSB on the shift.
    always_comb begin
        sum     = {1'b0, hi} + (bit_in ? {1'b0, mcand} : '0);
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo_upper};
    end

endmodule

// File: rtl/mult_seq.sv
// Sequential signed/unsigned multiplier with optional accumulate into the product registers.
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic             acc,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] multiplicand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] productHI,
    output logic [WIDTH-1:0] productLO
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             acc_q;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    prod_signed;
    logic [PW-1:0]    fix_result;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        a_mag = (sign && multiplier[WIDTH-1])   ? (~multiplier) + WIDTH'(1)   : multiplier;
        b_mag = (sign && multiplicand[WIDTH-1]) ? (~multiplicand) + WIDTH'(1) : multiplicand;
    end

    always_comb begin
        prod_signed = neg_q ? (~{acc_hi, acc_lo}) + PW'(1) : {acc_hi, acc_lo};
        fix_result  = acc_q ? prod_signed + {productHI, productLO} : prod_signed;
    end

    mult_step #(.WIDTH(WIDTH)) u_step (
        .hi       (acc_hi),
        .lo_upper (acc_lo[WIDTH-1:1]),
        .mcand    (mcand),
        .bit_in   (mplier[0]),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            productHI <= '0;
            productLO <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            acc_q     <= 1'b0;
            mplier    <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_q  <= sign & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                        acc_q  <= acc;
                        mplier <= a_mag;
                        mcand  <= b_mag;
                    end
                end
                LOAD: begin
                    acc_hi <= '0;
                    acc_lo <= '0;
                    cnt    <= CNT_W'(WIDTH);
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                end
                FIX: begin
                    productHI <= fix_result[PW-1:WIDTH];
                    productLO <= fix_result[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
